// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a word over valid/ready and shifts it out one
// bit per clock, with an optional trailing even-parity bit. Every output is a flop.
//
// state | meaning
// IDLE  | no frame on the line; ready for a word, ser_out/ser_valid low
// SHIFT | frame bits on ser_out; cnt_q is the index of the bit currently driven
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int         FLEN      = WIDTH + int'(PARITY_EN);
    localparam logic [5:0] LAST_IDX  = 6'(FLEN - 1);
    localparam logic [5:0] DATA_LAST = 6'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             load_ready_q, load_ready_d;

    logic             xfer;
    logic             load_bit;
    logic [WIDTH-1:0] load_rest;
    logic             shift_bit;
    logic [WIDTH-1:0] shift_rest;

    assign xfer = load_valid & load_ready_q;

    // The register holds only the bits not yet driven, so the next bit always sits at one end.
    assign load_bit   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign load_rest  = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
    assign shift_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shift_rest = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        par_d         = par_q;
        cnt_d         = cnt_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        load_ready_d  = load_ready_q;

        if (xfer) begin
            state_d       = SHIFT;
            shreg_d       = load_rest;
            par_d         = ^load_data;
            cnt_d         = 6'd0;
            ser_out_d     = load_bit;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            load_ready_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    load_ready_d = 1'b1;
                end
                SHIFT: begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d        = cnt_q + 6'd1;
                        ser_valid_d  = 1'b1;
                        ser_out_d    = (PARITY_EN && (cnt_q == DATA_LAST)) ? par_q : shift_bit;
                        shreg_d      = shift_rest;
                        load_ready_d = (cnt_d == LAST_IDX);
                    end else begin
                        state_d      = IDLE;
                        cnt_d        = 6'd0;
                        load_ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    load_ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            cnt_q         <= 6'd0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            load_ready_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            par_q         <= par_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            load_ready_q  <= load_ready_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = ser_valid_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first instance without parity and one
// LSB-first instance with parity, both checked against hand-written bit streams.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] da, db;
    logic       va, vb;
    logic       rdy_a, so_a, sv_a, fs_a, bz_a;
    logic       rdy_b, so_b, sv_b, fs_b, bz_b;
    logic       sel;
    logic       o_rdy, o_so, o_sv, o_fs, o_bz;
    logic [15:0] exp_bits;
    int         n_run = 0;
    int         n_fail = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_a (
        .clk(clk), .reset(reset), .load_data(da), .load_valid(va), .load_ready(rdy_a),
        .ser_out(so_a), .ser_valid(sv_a), .frame_start(fs_a), .busy(bz_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .load_data(db), .load_valid(vb), .load_ready(rdy_b),
        .ser_out(so_b), .ser_valid(sv_b), .frame_start(fs_b), .busy(bz_b)
    );

    assign o_rdy = sel ? rdy_b : rdy_a;
    assign o_so  = sel ? so_b  : so_a;
    assign o_sv  = sel ? sv_b  : sv_a;
    assign o_fs  = sel ? fs_b  : fs_a;
    assign o_bz  = sel ? bz_b  : bz_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        if (sel) begin
            db = d;
            vb = v;
        end else begin
            da = d;
            va = v;
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!o_rdy && k < 40) begin
            step();
            k++;
        end
        check(tag, 32'(o_rdy), 32'd1);
    endtask

    task automatic chk_bit(input string tag, input logic b, input logic fs, input logic rdy);
        check({tag, "_sv"},  32'(o_sv),  32'd1);
        check({tag, "_so"},  32'(o_so),  32'(b));
        check({tag, "_fs"},  32'(o_fs),  32'(fs));
        check({tag, "_rdy"}, 32'(o_rdy), 32'(rdy));
        check({tag, "_bz"},  32'(o_bz),  32'd1);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_sv"}, 32'(o_sv), 32'd0);
        check({tag, "_so"}, 32'(o_so), 32'd0);
        check({tag, "_bz"}, 32'(o_bz), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel   = 1'b0;
        reset = 1'b0;
        da    = 8'hFF;
        va    = 1'b1;
        db    = 8'h00;
        vb    = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_rdy", 32'(rdy_a), 32'd0);
            check("rst_sv",  32'(sv_a),  32'd0);
            check("rst_so",  32'(so_a),  32'd0);
        end
        reset = 1'b1;
        step();
        check("rdy_after_rst", 32'(rdy_a), 32'd1);
        chk_idle("post_rst");
        va = 1'b0;

        // single MSB-first frame A5
        exp_bits = 16'b10100101;
        wait_ready("a5_wait");
        drive(8'hA5, 1'b1);
        step();
        drive(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_bit("a5", exp_bits[7-i], i == 0, i == 7);
            step();
        end
        chk_idle("a5_end");
        check("a5_end_rdy", 32'(o_rdy), 32'd1);

        // LSB-first with parity: 07 -> 11100000 then parity 1
        sel = 1'b1;
        exp_bits = 16'b111000001;
        wait_ready("p07_wait");
        drive(8'h07, 1'b1);
        step();
        drive(8'h00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk_bit("p07", exp_bits[8-i], i == 0, i == 8);
            step();
        end
        chk_idle("p07_end");
        sel = 1'b0;

        // back-to-back 3C then C3
        exp_bits = 16'b0011110011000011;
        wait_ready("b2b_wait");
        drive(8'h3C, 1'b1);
        step();
        drive(8'hC3, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk_bit("b2b", exp_bits[15-i], (i == 0) || (i == 8), (i == 7) || (i == 15));
            if (i == 8) drive(8'h00, 1'b0);
            step();
        end
        chk_idle("b2b_end");

        // load_valid/load_data disturbed during the 81 frame; FF taken only at the last bit
        exp_bits = 16'b10000001;
        wait_ready("dist_wait");
        drive(8'h81, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            chk_bit("dist", exp_bits[7-i], i == 0, i == 7);
            if (i == 7 || (i % 2) == 0) drive(8'hFF, 1'b1);
            else drive(8'h5A, 1'b1);
            step();
        end
        chk_bit("ff", 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b0);
        step();
        for (int i = 1; i < 8; i++) begin
            chk_bit("ff", 1'b1, 1'b0, i == 7);
            step();
        end
        chk_idle("ff_end");

        // reset asserted while bit 3 of F0 is on the line
        exp_bits = 16'b11110000;
        wait_ready("f0_wait");
        drive(8'hF0, 1'b1);
        step();
        drive(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_bit("f0", exp_bits[7-i], i == 0, 1'b0);
            if (i < 3) step();
        end
        reset = 1'b0;
        step();
        chk_idle("mid_rst");
        check("mid_rst_fs",  32'(o_fs),  32'd0);
        check("mid_rst_rdy", 32'(o_rdy), 32'd0);
        reset = 1'b1;
        step();
        check("rel_rdy", 32'(o_rdy), 32'd1);
        chk_idle("rel");

        exp_bits = 16'b01010101;
        drive(8'h55, 1'b1);
        step();
        drive(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_bit("x55", exp_bits[7-i], i == 0, i == 7);
            step();
        end
        chk_idle("x55_end");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
